// File: rtl/cart_read_controller.sv
// cart_read_controller
//   Serves cartridge-bus reads from a word-wide memory. The host latches a
//   32-bit byte address with ALE_H/ALE_L, then pulses RD once per 16-bit word.
//   The controller fetches one word ahead. It drives the fetched word onto
//   the AD pad for each RD pulse and advances the address by 2 after each
//   pulse.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   cart_ad_sync   synchronized cartridge AD bus (address phase input)
//   cart_rd_sync   synchronized RD strobe (active low)
//   cart_alel_sync synchronized ALE_L strobe (falling edge latches addr[15:0])
//   cart_aleh_sync synchronized ALE_H strobe (falling edge latches addr[31:16])
//   mem_addr       byte address of the word being fetched (bit 0 always 0)
//   mem_req        fetch request, held until mem_ack
//   mem_ack        single-cycle acknowledge, mem_rdata valid in the same cycle
//   mem_rdata      fetched word
//   cart_ad_out    data toward the AD pad
//   cart_ad_oe     AD pad output enable
//   busy           high whenever the FSM is not idle
//   err_underrun   sticky: RD fell before the fetched word was available

`timescale 1ns / 1ps

module cart_read_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cart_ad_sync,
    input  logic        cart_rd_sync,
    input  logic        cart_alel_sync,
    input  logic        cart_aleh_sync,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] cart_ad_out,
    output logic        cart_ad_oe,
    output logic        busy,
    output logic        err_underrun
);

    typedef enum logic [2:0] {
        StIdle,
        StAddrH,
        StFetch,
        StReady,
        StDrive,
        StFlush
    } state_e;

    state_e      r_state;
    logic        r_primed;       // masks edge detection for the first cycle after reset
    logic        r_rd_prev;
    logic        r_alel_prev;
    logic        r_aleh_prev;
    logic [31:0] r_addr;         // working address, tracks ALE latches and increments
    logic [31:0] r_mem_addr;     // copy presented to memory, frozen while a request is open
    logic        r_mem_req;
    logic [15:0] r_buf;
    logic [15:0] r_ad_out;
    logic        r_oe;
    logic        r_busy;
    logic        r_err;
    logic        r_und_pend;     // RD already fell while the fetch was outstanding
    logic        r_flush_aleh;   // ALE_H fell while draining an aborted fetch

    logic        w_rd_fall;
    logic        w_rd_rise;
    logic        w_alel_fall;
    logic        w_alel_rise;
    logic        w_aleh_fall;
    logic        w_aleh_rise;
    logic        w_active;
    logic        w_abort;
    logic        w_und_now;
    logic        w_advance;
    logic [31:0] w_addr_next;

    always_comb begin
        w_rd_fall   = r_primed & r_rd_prev & ~cart_rd_sync;
        w_rd_rise   = r_primed & ~r_rd_prev & cart_rd_sync;
        w_alel_fall = r_primed & r_alel_prev & ~cart_alel_sync;
        w_alel_rise = r_primed & ~r_alel_prev & cart_alel_sync;
        w_aleh_fall = r_primed & r_aleh_prev & ~cart_aleh_sync;
        w_aleh_rise = r_primed & ~r_aleh_prev & cart_aleh_sync;

        w_active  = (r_state == StFetch) | (r_state == StReady) | (r_state == StDrive);
        // A new address phase starting mid-transfer abandons the transfer.
        w_abort   = w_active & (w_alel_rise | w_aleh_rise);
        // An RD rise while still waiting means the host gave up on that word.
        w_und_now = (r_und_pend & ~w_rd_rise) | w_rd_fall;
        w_advance = (r_state == StDrive) & w_rd_rise & ~w_abort;

        w_addr_next = r_addr;
        if (w_advance) begin
            w_addr_next = r_addr + 32'd2;
        end
        if (w_aleh_fall) begin
            w_addr_next[31:16] = cart_ad_sync;
        end
        if (w_alel_fall) begin
            w_addr_next[15:0] = cart_ad_sync & 16'hFFFE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_primed     <= 1'b0;
            r_rd_prev    <= 1'b0;
            r_alel_prev  <= 1'b0;
            r_aleh_prev  <= 1'b0;
            r_addr       <= 32'd0;
            r_mem_addr   <= 32'd0;
            r_mem_req    <= 1'b0;
            r_buf        <= 16'd0;
            r_ad_out     <= 16'd0;
            r_oe         <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_und_pend   <= 1'b0;
            r_flush_aleh <= 1'b0;
        end else begin
            r_primed    <= 1'b1;
            r_rd_prev   <= cart_rd_sync;
            r_alel_prev <= cart_alel_sync;
            r_aleh_prev <= cart_aleh_sync;
            r_addr      <= w_addr_next;
            if (!r_mem_req) begin
                r_mem_addr <= w_addr_next;
            end

            case (r_state)
                StIdle: begin
                    if (w_aleh_fall) begin
                        r_state <= StAddrH;
                        r_busy  <= 1'b1;
                    end
                end

                StAddrH: begin
                    if (w_alel_fall) begin
                        r_state   <= StFetch;
                        r_mem_req <= 1'b1;
                    end
                end

                StFetch: begin
                    if (w_abort) begin
                        r_und_pend <= 1'b0;
                        if (mem_ack) begin
                            // Fetch completed in the abort cycle: nothing left to drain.
                            r_mem_req <= 1'b0;
                            if (w_aleh_fall) begin
                                r_state <= StAddrH;
                            end else begin
                                r_state <= StIdle;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_state      <= StFlush;
                            r_flush_aleh <= w_aleh_fall;
                        end
                    end else begin
                        if (w_rd_fall) begin
                            r_err <= 1'b1;
                        end
                        if (mem_ack) begin
                            r_mem_req  <= 1'b0;
                            r_buf      <= mem_rdata;
                            r_und_pend <= 1'b0;
                            if (w_und_now) begin
                                r_state  <= StDrive;
                                r_oe     <= 1'b1;
                                r_ad_out <= mem_rdata;
                            end else begin
                                r_state <= StReady;
                            end
                        end else begin
                            r_und_pend <= w_und_now;
                        end
                    end
                end

                StReady: begin
                    if (w_abort) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else if (w_rd_fall) begin
                        r_state  <= StDrive;
                        r_oe     <= 1'b1;
                        r_ad_out <= r_buf;
                    end
                end

                StDrive: begin
                    if (w_abort) begin
                        r_state <= StIdle;
                        r_oe    <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_rd_rise) begin
                        r_state   <= StFetch;
                        r_oe      <= 1'b0;
                        r_mem_req <= 1'b1;
                    end
                end

                StFlush: begin
                    if (mem_ack) begin
                        r_mem_req    <= 1'b0;
                        r_flush_aleh <= 1'b0;
                        if (r_flush_aleh | w_aleh_fall) begin
                            r_state <= StAddrH;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_aleh_fall) begin
                        r_flush_aleh <= 1'b1;
                    end
                end

                default: begin
                    r_state   <= StIdle;
                    r_mem_req <= 1'b0;
                    r_oe      <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr     = r_mem_addr;
    assign mem_req      = r_mem_req;
    assign cart_ad_out  = r_ad_out;
    assign cart_ad_oe   = r_oe;
    assign busy         = r_busy;
    assign err_underrun = r_err;

endmodule

// File: doc/cart_read_controller.md
CART_READ_CONTROLLER -- requirements
Module: cart_read_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port cart_ad_sync, input, 16 bits: cartridge AD bus, already two-stage synchronized to clk.
REQ-004 SHALL have ports cart_rd_sync, cart_alel_sync and cart_aleh_sync, inputs, 1 bit each: synchronized RD, ALE_L and ALE_H strobes.
REQ-005 SHALL have port mem_addr, output, 32 bits: byte address of the word being fetched; bit 0 is always 0.
REQ-006 SHALL have port mem_req, output, 1 bit: fetch request, held high until mem_ack.
REQ-007 SHALL have port mem_ack, input, 1 bit: single-cycle acknowledge; mem_rdata is valid in the same cycle.
REQ-008 SHALL have port mem_rdata, input, 16 bits: fetched word.
REQ-009 SHALL have ports cart_ad_out, output, 16 bits, and cart_ad_oe, output, 1 bit: data and output enable toward the AD pad.
REQ-010 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 SHALL have port err_underrun, output, 1 bit: sticky flag set when RD falls before the data is ready.

Function
REQ-012 SHALL detect edges by comparing each synced strobe with a one-cycle-delayed copy; fall = prev & ~cur, rise = ~prev & cur.
REQ-013 SHALL latch cart_ad_sync into addr[31:16] on every ALE_H fall, in any state.
REQ-014 SHALL latch cart_ad_sync & 16'hFFFE into addr[15:0] on every ALE_L fall, in any state.
REQ-015 SHALL implement the states IDLE, ADDR_H, FETCH, READY, DRIVE and FLUSH.
REQ-016 SHALL make the following transitions:
- IDLE -> ADDR_H on an ALE_H fall.
- ADDR_H -> FETCH on an ALE_L fall.
- FETCH -> READY on mem_ack.
- READY -> DRIVE on an RD fall.
- DRIVE -> FETCH on an RD rise.
REQ-017 SHALL assert mem_req in the first cycle of FETCH, which is the cycle after the triggering edge was detected, and deassert it in the cycle after mem_ack.
REQ-018 SHALL capture mem_rdata into a 16-bit buffer in the mem_ack cycle, and SHALL ignore mem_ack at all other times.
REQ-019 SHALL hold mem_addr stable while mem_req is high.
REQ-020 SHALL, on leaving DRIVE, increment mem_addr by 2 modulo 2^32 (0xFFFFFFFE wraps to 0x00000000).
REQ-021 SHALL assert cart_ad_oe, with cart_ad_out equal to the buffer, one cycle after the RD fall is detected, and SHALL deassert cart_ad_oe one cycle after the RD rise is detected.
REQ-022 SHALL handle an RD fall in FETCH (underrun) as follows:
- set err_underrun;
- enter DRIVE when mem_ack arrives;
- drive the buffer contents one cycle after that ack.
REQ-023 SHALL treat an ALE_H or ALE_L rise in FETCH, READY or DRIVE as an abort:
- cart_ad_oe drops in the next cycle;
- FETCH goes to FLUSH;
- READY and DRIVE go to IDLE.
REQ-024 SHALL, in FLUSH, hold mem_req until mem_ack, discard that data, then go to ADDR_H if an ALE_H fall occurred during FLUSH, otherwise to IDLE.
REQ-025 SHALL give priority to abort over RD edges when both occur in the same cycle.
REQ-026 SHALL ignore RD edges in IDLE, ADDR_H and FLUSH.
REQ-027 SHALL hold cart_ad_oe low whenever the state is not DRIVE.

Reset
REQ-028 SHALL, while reset is low, force the following values asynchronously:
- state to IDLE;
- mem_addr to 0, mem_req to 0;
- cart_ad_out to 0, cart_ad_oe to 0;
- busy to 0, err_underrun to 0;
- the buffer and all edge-detect registers to 0.
REQ-029 SHALL report no edge in the first cycle after reset is released, whatever the input levels.
REQ-030 SHALL clear err_underrun only through reset.

Verification
REQ-031 SHALL cover a basic read:
- stimulus: ALE_H fall with AD=0x1000, ALE_L fall with AD=0x0040, ack returns 0xBEEF, RD pulse;
- response: mem_addr=0x10000040, cart_ad_out=0xBEEF with oe high during RD, then next mem_req at 0x10000042.
REQ-032 SHALL cover a burst: 4 RD pulses with ack data 0x0001..0x0004 -> AD carries 1, 2, 3, 4 in order; final mem_addr = base+8.
REQ-033 SHALL cover wrap: address 0xFFFFFFFE with one RD pulse -> next mem_addr = 0x00000000.
REQ-034 SHALL cover underrun: ack delayed 10 cycles past the RD fall -> err_underrun=1, oe rises one cycle after the ack, and the flag persists until reset.
REQ-035 SHALL cover abort: ALE_H rises while mem_req is pending -> mem_req stays high until ack, oe never asserts, state ends IDLE.
REQ-036 SHALL cover mid-operation reset: reset low during DRIVE -> oe=0, mem_req=0 and busy=0 immediately (asynchronously), with no spurious edge after release.
